// File: rtl/immediate_decode_stage.sv
// Immediate decode stage: RV32/RV64 immediate extraction and branch target.
// Decoded entries are held in a one- or two-deep buffer with a valid/ready handshake.
module immediate_decode_stage #(
   parameter int XLEN    = 32,
   parameter bit SKID_EN = 1'b1,
   parameter bit ZIMM_EN = 1'b1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     in_inst,
   input  logic [XLEN-1:0] in_pc,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_imm,
   output logic [XLEN-1:0] out_target,
   output logic [2:0]      out_fmt,
   output logic            out_illegal
);

   if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
      $error("XLEN must be 32 or 64");
   end

   typedef enum logic [2:0] {
      FMT_R    = 3'd0,
      FMT_I    = 3'd1,
      FMT_S    = 3'd2,
      FMT_B    = 3'd3,
      FMT_U    = 3'd4,
      FMT_J    = 3'd5,
      FMT_ZIMM = 3'd6,
      FMT_ILL  = 3'd7
   } fmt_e;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] imm;
      fmt_e            fmt;
   } entry_t;

   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_IMM = 7'b0010011;
   localparam logic [6:0] OP_LD  = 7'b0000011;
   localparam logic [6:0] OP_JLR = 7'b1100111;
   localparam logic [6:0] OP_ST  = 7'b0100011;
   localparam logic [6:0] OP_BR  = 7'b1100011;
   localparam logic [6:0] OP_LUI = 7'b0110111;
   localparam logic [6:0] OP_AUI = 7'b0010111;
   localparam logic [6:0] OP_JAL = 7'b1101111;
   localparam logic [6:0] OP_SYS = 7'b1110011;

   logic signed [31:0] i32;
   logic signed [31:0] s32;
   logic signed [31:0] b32;
   logic signed [31:0] u32;
   logic signed [31:0] j32;
   logic [5:0]         shamt;
   logic [2:0]         funct3;
   logic               is_shift;
   logic [XLEN-1:0]    dec_imm;
   fmt_e               dec_fmt;
   entry_t             dec;

   entry_t     e0;
   entry_t     e1;
   entry_t     n_e0;
   entry_t     n_e1;
   logic [1:0] cnt;
   logic [1:0] n_cnt;
   logic       rdy_q;
   logic       push;
   logic       pop;

   assign funct3   = in_inst[14:12];
   assign is_shift = (funct3 == 3'b001) || (funct3 == 3'b101);
   assign shamt    = (XLEN == 64) ? in_inst[25:20]
                                  : {1'b0, in_inst[24:20]};

   assign i32 = {{20{in_inst[31]}}, in_inst[31:20]};
   assign s32 = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
   assign b32 = {{19{in_inst[31]}}, in_inst[31], in_inst[7],
                 in_inst[30:25], in_inst[11:8], 1'b0};
   assign u32 = {in_inst[31:12], 12'b0};
   assign j32 = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12],
                 in_inst[20], in_inst[30:21], 1'b0};

   // Opcode decode into format code and XLEN-wide immediate.
   always_comb begin
      dec_imm = '0;
      dec_fmt = FMT_ILL;
      if (in_inst[1:0] == 2'b11) begin
         unique case (in_inst[6:0])
            OP_R: dec_fmt = FMT_R;
            OP_IMM: begin
               if (!is_shift) begin
                  dec_fmt = FMT_I;
                  dec_imm = XLEN'(i32);
               end else if (XLEN == 32 && in_inst[25]) begin
                  dec_fmt = FMT_ILL;
               end else begin
                  dec_fmt = FMT_I;
                  dec_imm = {{(XLEN-6){1'b0}}, shamt};
               end
            end
            OP_LD, OP_JLR: begin
               dec_fmt = FMT_I;
               dec_imm = XLEN'(i32);
            end
            OP_ST: begin
               dec_fmt = FMT_S;
               dec_imm = XLEN'(s32);
            end
            OP_BR: begin
               dec_fmt = FMT_B;
               dec_imm = XLEN'(b32);
            end
            OP_LUI, OP_AUI: begin
               dec_fmt = FMT_U;
               dec_imm = XLEN'(u32);
            end
            OP_JAL: begin
               dec_fmt = FMT_J;
               dec_imm = XLEN'(j32);
            end
            OP_SYS: begin
               if (ZIMM_EN && in_inst[14]) begin
                  dec_fmt = FMT_ZIMM;
                  dec_imm = {{(XLEN-5){1'b0}}, in_inst[19:15]};
               end else begin
                  dec_fmt = FMT_I;
                  dec_imm = XLEN'(i32);
               end
            end
            default: begin
               dec_fmt = FMT_ILL;
               dec_imm = '0;
            end
         endcase
      end
   end

   assign dec.pc  = in_pc;
   assign dec.imm = dec_imm;
   assign dec.fmt = dec_fmt;

   assign out_valid = (cnt != 2'd0);
   assign in_ready  = SKID_EN ? rdy_q
                              : (rdy_q && (!out_valid || out_ready));
   assign push      = in_valid && in_ready && !flush;
   assign pop       = out_valid && out_ready && !flush;

   // Buffer next-state: head always presents, tail queues behind it.
   always_comb begin
      n_e0  = e0;
      n_e1  = e1;
      n_cnt = cnt;
      if (flush) begin
         n_cnt = 2'd0;
      end else begin
         unique case (cnt)
            2'd0: begin
               if (push) begin
                  n_e0  = dec;
                  n_cnt = 2'd1;
               end
            end
            2'd1: begin
               if (push && pop) begin
                  n_e0 = dec;
               end else if (push) begin
                  n_e1  = dec;
                  n_cnt = 2'd2;
               end else if (pop) begin
                  n_cnt = 2'd0;
               end
            end
            default: begin
               if (pop) begin
                  n_e0 = e1;
                  if (push) begin
                     n_e1 = dec;
                  end else begin
                     n_cnt = 2'd1;
                  end
               end
            end
         endcase
      end
   end

   // State registers; reset clears every entry so outputs read zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         e0    <= '0;
         e1    <= '0;
         cnt   <= 2'd0;
         rdy_q <= 1'b0;
      end else begin
         e0    <= n_e0;
         e1    <= n_e1;
         cnt   <= n_cnt;
         rdy_q <= SKID_EN ? (n_cnt != 2'd2) : 1'b1;
      end
   end

   assign out_imm     = e0.imm;
   assign out_target  = e0.pc + e0.imm;
   assign out_fmt     = e0.fmt;
   assign out_illegal = (e0.fmt == FMT_ILL);

endmodule

// File: tb/tb_immediate_decode_stage.sv
// Directed bench for immediate_decode_stage.
// Covers RV32 and RV64 decode, skid buffering, flush and reset.
module tb_immediate_decode_stage;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        flush = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] in_inst = '0;
   logic [31:0] in_pc = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_imm;
   logic [31:0] out_target;
   logic [2:0]  out_fmt;
   logic        out_illegal;

   logic        v64 = 1'b0;
   logic        rdy64;
   logic [31:0] inst64 = '0;
   logic [63:0] pc64 = '0;
   logic        ov64;
   logic [63:0] imm64;
   logic [63:0] tgt64;
   logic [2:0]  fmt64;
   logic        ill64;

   int n_chk = 0;
   int n_pass = 0;

   immediate_decode_stage #(
      .XLEN(32), .SKID_EN(1'b1), .ZIMM_EN(1'b1)
   ) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_inst(in_inst), .in_pc(in_pc),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_imm(out_imm), .out_target(out_target),
      .out_fmt(out_fmt), .out_illegal(out_illegal)
   );

   immediate_decode_stage #(
      .XLEN(64), .SKID_EN(1'b1), .ZIMM_EN(1'b1)
   ) dut64 (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_valid(v64), .in_ready(rdy64),
      .in_inst(inst64), .in_pc(pc64),
      .out_valid(ov64), .out_ready(1'b1),
      .out_imm(imm64), .out_target(tgt64),
      .out_fmt(fmt64), .out_illegal(ill64)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag,
                      input logic [63:0] got,
                      input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h",
                    tag, got, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [31:0] inst,
                       input logic [31:0] pc);
      in_valid = 1'b1;
      in_inst  = inst;
      in_pc    = pc;
      step();
      in_valid = 1'b0;
   endtask

   task automatic check_out(input string tag,
                            input logic [31:0] imm,
                            input logic [31:0] tgt,
                            input logic [2:0] fmt,
                            input logic ill);
      chk({tag, "_v"}, 64'(out_valid), 64'd1);
      chk({tag, "_imm"}, 64'(out_imm), 64'(imm));
      chk({tag, "_tgt"}, 64'(out_target), 64'(tgt));
      chk({tag, "_fmt"}, 64'(out_fmt), 64'(fmt));
      chk({tag, "_ill"}, 64'(out_illegal), 64'(ill));
   endtask

   initial begin
      int acc;
      logic pre;

      // reset state, no clock edge needed
      #2;
      chk("rst_valid", 64'(out_valid), 64'd0);
      chk("rst_ready", 64'(in_ready), 64'd0);
      chk("rst_imm", 64'(out_imm), 64'd0);
      chk("rst_tgt", 64'(out_target), 64'd0);
      chk("rst_fmt", 64'(out_fmt), 64'd0);
      chk("rst_ill", 64'(out_illegal), 64'd0);
      step();
      chk("rst_hold_ready", 64'(in_ready), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      step();
      chk("ready_after_rst", 64'(in_ready), 64'd1);

      // single-entry decodes, drained every cycle
      out_ready = 1'b1;
      send(32'hFFF00093, 32'h100);
      check_out("addi", 32'hFFFFFFFF, 32'h000000FF, 3'd1, 1'b0);
      send(32'hFFDFF0EF, 32'h0);
      check_out("jal", 32'hFFFFFFFC, 32'hFFFFFFFC, 3'd5, 1'b0);
      send(32'h000FD073, 32'h40);
      check_out("csrrwi", 32'h1F, 32'h5F, 3'd6, 1'b0);
      send(32'h00000000, 32'h80);
      check_out("zero", 32'h0, 32'h80, 3'd7, 1'b1);
      send(32'hFE112E23, 32'h200);
      check_out("sw", 32'hFFFFFFFC, 32'h1FC, 3'd2, 1'b0);
      send(32'hFE000EE3, 32'h300);
      check_out("beq", 32'hFFFFFFFC, 32'h2FC, 3'd3, 1'b0);
      send(32'h40515093, 32'h10);
      check_out("srai", 32'h5, 32'h15, 3'd1, 1'b0);
      send(32'h02001013, 32'h10);
      check_out("slli32", 32'h0, 32'h10, 3'd7, 1'b1);
      send(32'h00000033, 32'h44);
      check_out("add", 32'h0, 32'h44, 3'd0, 1'b0);
      send(32'h00001073, 32'h0);
      check_out("csrrw", 32'h0, 32'h0, 3'd1, 1'b0);
      step();
      chk("drained", 64'(out_valid), 64'd0);

      // RV64 decodes
      v64 = 1'b1;
      inst64 = 32'h800000B7;
      pc64 = 64'h1000;
      step();
      inst64 = 32'h02001013;
      chk("lui64_imm", imm64, 64'hFFFFFFFF80000000);
      chk("lui64_fmt", 64'(fmt64), 64'd4);
      chk("lui64_tgt", tgt64, 64'hFFFFFFFF80001000);
      step();
      v64 = 1'b0;
      chk("slli64_imm", imm64, 64'd32);
      chk("slli64_fmt", 64'(fmt64), 64'd1);

      // skid: three offered against a stalled sink
      out_ready = 1'b0;
      acc = 0;
      for (int c = 0; c < 5; c++) begin
         in_valid = (acc < 3);
         in_inst  = (32'(acc + 1) << 20) | 32'h93;
         in_pc    = 32'h0;
         pre = in_ready;
         step();
         if (pre && in_valid) acc++;
      end
      in_valid = 1'b0;
      chk("skid_acc", 64'(acc), 64'd2);
      chk("skid_ready", 64'(in_ready), 64'd0);
      chk("skid_hold", 64'(out_imm), 64'd1);
      out_ready = 1'b1;
      check_out("skid0", 32'd1, 32'd1, 3'd1, 1'b0);
      step();
      check_out("skid1", 32'd2, 32'd2, 3'd1, 1'b0);
      chk("skid_ready2", 64'(in_ready), 64'd1);
      step();
      chk("skid_empty", 64'(out_valid), 64'd0);

      // flush while full, with a new instruction offered
      out_ready = 1'b0;
      send(32'h00100093, 32'h0);
      send(32'h00200093, 32'h0);
      chk("fl_full", 64'(in_ready), 64'd0);
      flush = 1'b1;
      in_valid = 1'b1;
      in_inst = 32'h00300093;
      step();
      flush = 1'b0;
      in_valid = 1'b0;
      chk("fl_valid", 64'(out_valid), 64'd0);
      chk("fl_ready", 64'(in_ready), 64'd1);
      out_ready = 1'b1;
      acc = 0;
      for (int c = 0; c < 3; c++) begin
         step();
         if (out_valid) acc++;
      end
      chk("fl_none", 64'(acc), 64'd0);

      // flush with an accept into a one-entry stage
      out_ready = 1'b0;
      send(32'h00400093, 32'h0);
      flush = 1'b1;
      in_valid = 1'b1;
      in_inst = 32'h00500093;
      step();
      flush = 1'b0;
      in_valid = 1'b0;
      chk("fl1_valid", 64'(out_valid), 64'd0);
      step();
      chk("fl1_none", 64'(out_valid), 64'd0);

      // reset mid-transfer drops held entries
      send(32'h00600093, 32'h0);
      chk("mr_held", 64'(out_valid), 64'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("mr_valid", 64'(out_valid), 64'd0);
      chk("mr_ready", 64'(in_ready), 64'd0);
      chk("mr_imm", 64'(out_imm), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      out_ready = 1'b1;
      step();
      chk("mr_none", 64'(out_valid), 64'd0);
      chk("mr_ready2", 64'(in_ready), 64'd1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
